// File: rtl/sample_window_stats_if.sv
// sample_window_stats_if
//   Groups the sample stream and the per-window result bus of the
//   window statistics stage.
//
//   Signals:
//     dataInput   [15:0] signed sample from the offset-removal stage
//     dataValid          qualifies dataInput for the current cycle
//     enable             high to accumulate windows, low to abort and idle
//     peakMax     [15:0] signed maximum of the last completed window
//     peakMin     [15:0] signed minimum of the last completed window
//     peakToPeak  [16:0] unsigned peakMax - peakMin
//     meanOut     [15:0] signed floor mean of the last completed window
//     resultValid        one-cycle pulse when the results update
//
//   Modports:
//     master  the producer of samples and consumer of results
//     slave   the statistics stage itself
interface sample_window_stats_if;

  logic [15:0] dataInput;
  logic        dataValid;
  logic        enable;
  logic [15:0] peakMax;
  logic [15:0] peakMin;
  logic [16:0] peakToPeak;
  logic [15:0] meanOut;
  logic        resultValid;

  modport master (
    output dataInput,
    output dataValid,
    output enable,
    input  peakMax,
    input  peakMin,
    input  peakToPeak,
    input  meanOut,
    input  resultValid
  );

  modport slave (
    input  dataInput,
    input  dataValid,
    input  enable,
    output peakMax,
    output peakMin,
    output peakToPeak,
    output meanOut,
    output resultValid
  );

endinterface

// File: rtl/sample_window_stats.sv
// sample_window_stats
//   Splits the incoming sample stream into consecutive non-overlapping
//   windows of 2^WINDOW_LOG2 valid samples and publishes, for every
//   completed window, its maximum, minimum, peak-to-peak amplitude and
//   floor-rounded mean, together with a one-cycle resultValid pulse.
//   Dropping enable aborts the window in progress without touching the
//   published results.
//
//   Parameters:
//     WINDOW_LOG2  log2 of the window length (1..12)
//
//   Ports:
//     clk  system clock, rising edge
//     rst  asynchronous active-high reset
//     bus  slave side of sample_window_stats_if (samples in, results out)
module sample_window_stats #(
  parameter int WINDOW_LOG2 = 8
) (
  input logic                  clk,
  input logic                  rst,
  sample_window_stats_if.slave bus
);

  localparam int SUM_W = 16 + WINDOW_LOG2;
  localparam logic [WINDOW_LOG2-1:0] LAST_COUNT = '1;

  typedef enum logic {
    IDLE,
    ACCUM
  } state_t;

  state_t state;
  state_t next_state;

  logic [WINDOW_LOG2-1:0] count;
  logic signed [15:0]     run_max;
  logic signed [15:0]     run_min;
  logic signed [SUM_W-1:0] run_sum;

  logic signed [15:0] peak_max;
  logic signed [15:0] peak_min;
  logic [16:0]        peak_to_peak;
  logic signed [15:0] mean;
  logic               result_valid;

  logic                    consume;
  logic                    complete;
  logic signed [15:0]      sample;
  logic signed [SUM_W-1:0] sample_ext;
  logic                    first_sample;
  logic signed [15:0]      fold_max;
  logic signed [15:0]      fold_min;
  logic signed [SUM_W-1:0] fold_sum;
  logic [16:0]             fold_p2p;
  logic signed [15:0]      fold_mean;

  // State register for the IDLE/ACCUM controller.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. A sample is taken only while already accumulating,
  // and a low enable always wins over dataValid, even on the sample that
  // would have closed the window.
  always_comb begin
    next_state = state;
    consume    = 1'b0;
    complete   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.enable) begin
          next_state = ACCUM;
        end
      end
      ACCUM: begin
        if (!bus.enable) begin
          next_state = IDLE;
        end else if (bus.dataValid) begin
          consume  = 1'b1;
          complete = (count == LAST_COUNT);
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Fold the current sample into the running statistics. The first sample
  // of a window seeds max/min/sum rather than being compared against the
  // stale values of the previous window. The peak-to-peak difference is
  // formed on sign-extended 17-bit operands, so full-scale inputs give up
  // to 65535 without wrapping. Taking bits [WINDOW_LOG2 +: 16] of the sum
  // is exactly the low 16 bits of an arithmetic right shift, which gives
  // floor rounding toward minus infinity.
  always_comb begin
    sample       = signed'(bus.dataInput);
    sample_ext   = {{WINDOW_LOG2{bus.dataInput[15]}}, bus.dataInput};
    first_sample = (count == '0);
    fold_max     = run_max;
    fold_min     = run_min;
    fold_sum     = run_sum;
    if (first_sample) begin
      fold_max = sample;
      fold_min = sample;
      fold_sum = sample_ext;
    end else begin
      if (sample > run_max) begin
        fold_max = sample;
      end
      if (sample < run_min) begin
        fold_min = sample;
      end
      fold_sum = run_sum + sample_ext;
    end
    fold_p2p  = {fold_max[15], fold_max} - {fold_min[15], fold_min};
    fold_mean = fold_sum[WINDOW_LOG2 +: 16];
  end

  // Sample counter. Holding it at zero throughout IDLE guarantees that
  // every entry into ACCUM starts a fresh window; in ACCUM it wraps to
  // zero by itself after the last sample of a window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (state == IDLE) begin
      count <= '0;
    end else if (consume) begin
      count <= count + 1'b1;
    end
  end

  // Running max/min/sum of the window in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_max <= '0;
      run_min <= '0;
      run_sum <= '0;
    end else if (consume) begin
      run_max <= fold_max;
      run_min <= fold_min;
      run_sum <= fold_sum;
    end
  end

  // Published results. They change only when a window completes and are
  // deliberately left alone by aborts and by idling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      peak_max     <= '0;
      peak_min     <= '0;
      peak_to_peak <= '0;
      mean         <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= complete;
      if (complete) begin
        peak_max     <= fold_max;
        peak_min     <= fold_min;
        peak_to_peak <= fold_p2p;
        mean         <= fold_mean;
      end
    end
  end

  assign bus.peakMax     = peak_max;
  assign bus.peakMin     = peak_min;
  assign bus.peakToPeak  = peak_to_peak;
  assign bus.meanOut     = mean;
  assign bus.resultValid = result_valid;

endmodule

// File: doc/sample_window_stats.md
# sample_window_stats

Per-window statistics stage that sits directly downstream of the offset-removal stage. It consumes the 16-bit two's-complement samples that stage produces, with the 450-count DC offset already removed. Over consecutive non-overlapping windows of 2^WINDOW_LOG2 valid samples it tracks maximum, minimum, peak-to-peak amplitude and mean. It publishes each window's results as registered outputs with a one-cycle valid pulse, for the measurement/display logic further down the chain.

## Interface
- WINDOW_LOG2, default 8: window length is 2^WINDOW_LOG2 valid samples. Legal range 1..12.
- clk  input  1  single system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- dataInput  input  16  signed two's-complement sample from the offset-removal stage.
- dataValid  input  1  qualifies dataInput for the current cycle. No backpressure.
- enable  input  1  high: accumulate windows; low: abort the current window and idle.
- peakMax  output  16  signed maximum of the last completed window.
- peakMin  output  16  signed minimum of the last completed window.
- peakToPeak  output  17  unsigned peakMax − peakMin of the last completed window.
- meanOut  output  16  signed mean of the last completed window, floor-rounded.
- resultValid  output  1  one-cycle pulse when the result outputs update.

## Operation
- States:
  - IDLE → ACCUM on the first edge where enable=1.
  - ACCUM → IDLE on any edge where enable=0.
  - Entering ACCUM clears the sample counter (WINDOW_LOG2 bits).
- In ACCUM, a sample is consumed only on edges with dataValid=1. Cycles with dataValid=0 change nothing.
- First sample of a window (count==0): runMax=runMin=sample, runSum=sign-extended sample.
- Later samples: runMax/runMin updated by signed compare; runSum += sign-extended sample.
- runSum is 16+WINDOW_LOG2 bits signed and cannot overflow.
- Last sample (count==2^WINDOW_LOG2−1 with dataValid=1), on the same edge:
  - Fold the sample into the final max/min/sum.
  - Load peakMax, peakMin and peakToPeak = peakMax − peakMin, computed in 17 bits and always ≥0.
  - Load meanOut = final sum arithmetically shifted right by WINDOW_LOG2 (floor toward −∞), low 16 bits.
  - Set resultValid; wrap count to 0.
  - Stay in ACCUM; the next valid sample starts a new window. No dead cycle.
- Result outputs hold their values until the next completed window. They are not touched by aborts or IDLE.
- enable=0 with dataValid=1 on the same edge: the sample is discarded. The abort takes priority, including on what would have been the final sample, so no result is produced.
- Boundary cases:
  - Window of all-equal samples: peakToPeak=0.
  - Full-scale inputs: peakToPeak up to 65535; no saturation is needed.

## Timing
- Reset (async assert, synchronous-safe release):
  - State IDLE; count=0.
  - runMax, runMin, runSum = 0.
  - peakMax, peakMin, peakToPeak, meanOut = 0; resultValid=0.
- Latency: result outputs and resultValid are high in the cycle immediately after the edge that captured the final sample of a window.
- resultValid is high for exactly one cycle per completed window, even when the next sample arrives on that cycle. The next pulse follows at least 2^WINDOW_LOG2 cycles later.
- Throughput: one sample per clock sustained, with dataValid held high indefinitely.
- Reset mid-window: the partial window is lost and outputs return to 0 immediately. After release, the first window starts once enable is seen high.

## Test plan
All cases use WINDOW_LOG2=2 (4-sample windows).
- Reset check: assert rst mid-stream → all outputs 0 and resultValid 0 while rst=1. No pulse until 4 valid samples follow release.
- Basic window: enable=1; samples 10, −20, 30, 0 on consecutive cycles → next cycle resultValid=1, peakMax=30, peakMin=−20, peakToPeak=50, meanOut=5. resultValid=0 the cycle after.
- Floor rounding: samples −1, −1, −1, −2 → meanOut=−2 (sum −5), peakToPeak=1.
- Full scale: samples 32767, −32768, 0, 0 → peakMax=32767, peakMin=−32768, peakToPeak=65535, meanOut=−1.
- Gapped valid and back-to-back windows: 8 samples 1..8 with random dataValid gaps → exactly two pulses, with results (max 4, min 1, mean 2) then (max 8, min 5, mean 6). Unqualified dataInput values have no effect.
- Abort: 2 samples, then enable=0 for 3 cycles, then enable=1 with samples 4, 4, 4, 4 → no pulse during the abort and outputs unchanged. Exactly one pulse after the 4th new sample, with peakToPeak=0 and meanOut=4.
